// File: rtl/spu_register_file.sv
// SPU register file: 128x128 array, two write-back ports, three
// forwarded operand reads. Ports: clock, reset (async, active-low),
// even/odd write-back, even/odd staging, ra/rb/rc reads, collision flag.
module spu_register_file #(
  parameter int NUM_REGS = 128,
  parameter int DATA_W   = 128,
  parameter int STAGES   = 4,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [DATA_W-1:0]              even_wb_data,
  input  logic [AW-1:0]                  even_wb_reg_addr,
  input  logic                           even_wb_enable_reg_write,
  input  logic [DATA_W-1:0]              odd_wb_data,
  input  logic [AW-1:0]                  odd_wb_reg_addr,
  input  logic                           odd_wb_enable_reg_write,
  input  logic [STAGES-1:0][DATA_W-1:0]  even_stage_data,
  input  logic [STAGES-1:0][AW-1:0]      even_stage_addr,
  input  logic [STAGES-1:0]              even_stage_en,
  input  logic [STAGES-1:0][DATA_W-1:0]  odd_stage_data,
  input  logic [STAGES-1:0][AW-1:0]      odd_stage_addr,
  input  logic [STAGES-1:0]              odd_stage_en,
  input  logic                           rd_valid,
  input  logic [AW-1:0]                  ra_addr,
  input  logic [AW-1:0]                  rb_addr,
  input  logic [AW-1:0]                  rc_addr,
  output logic [DATA_W-1:0]              ra_data,
  output logic [DATA_W-1:0]              rb_data,
  output logic [DATA_W-1:0]              rc_data,
  output logic                           rd_data_valid,
  output logic                           wb_collision
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [2:0][AW-1:0]     op_addr;
  logic [2:0][DATA_W-1:0] op_val;

  assign op_addr = {rc_addr, rb_addr, ra_addr};

  // Lowest priority first; later hits override earlier ones, so the
  // youngest stage (k=0, odd pipe) ends up with the final say.
  always_comb begin
    op_val = '0;
    for (int i = 0; i < 3; i++) begin
      op_val[i] = regs[op_addr[i]];
      if (even_wb_enable_reg_write &&
          even_wb_reg_addr == op_addr[i])
        op_val[i] = even_wb_data;
      if (odd_wb_enable_reg_write &&
          odd_wb_reg_addr == op_addr[i])
        op_val[i] = odd_wb_data;
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (even_stage_en[k] &&
            even_stage_addr[k] == op_addr[i])
          op_val[i] = even_stage_data[k];
        if (odd_stage_en[k] &&
            odd_stage_addr[k] == op_addr[i])
          op_val[i] = odd_stage_data[k];
      end
    end
  end

  // Odd write is issued last so it wins on an address collision.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      if (even_wb_enable_reg_write)
        regs[even_wb_reg_addr] <= even_wb_data;
      if (odd_wb_enable_reg_write)
        regs[odd_wb_reg_addr] <= odd_wb_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ra_data       <= '0;
      rb_data       <= '0;
      rc_data       <= '0;
      rd_data_valid <= 1'b0;
      wb_collision  <= 1'b0;
    end else begin
      rd_data_valid <= rd_valid;
      wb_collision  <= even_wb_enable_reg_write &&
                       odd_wb_enable_reg_write &&
                       (even_wb_reg_addr == odd_wb_reg_addr);
      if (rd_valid) begin
        ra_data <= op_val[0];
        rb_data <= op_val[1];
        rc_data <= op_val[2];
      end
    end
  end

endmodule

// File: tb/tb_spu_register_file.sv
// Directed bench for spu_register_file: reset, write-back, collision,
// staging forwarding priority, flushed slots, write-through.
module tb_spu_register_file;

  localparam int DW = 128;
  localparam int AW = 7;
  localparam int ST = 4;

  logic                   clock;
  logic                   reset;
  logic [DW-1:0]          even_wb_data;
  logic [AW-1:0]          even_wb_reg_addr;
  logic                   even_wb_enable_reg_write;
  logic [DW-1:0]          odd_wb_data;
  logic [AW-1:0]          odd_wb_reg_addr;
  logic                   odd_wb_enable_reg_write;
  logic [ST-1:0][DW-1:0]  even_stage_data;
  logic [ST-1:0][AW-1:0]  even_stage_addr;
  logic [ST-1:0]          even_stage_en;
  logic [ST-1:0][DW-1:0]  odd_stage_data;
  logic [ST-1:0][AW-1:0]  odd_stage_addr;
  logic [ST-1:0]          odd_stage_en;
  logic                   rd_valid;
  logic [AW-1:0]          ra_addr, rb_addr, rc_addr;
  logic [DW-1:0]          ra_data, rb_data, rc_data;
  logic                   rd_data_valid;
  logic                   wb_collision;

  int total = 0;
  int bad   = 0;

  localparam logic [DW-1:0] C10 =
    128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DW-1:0] CAA = {16{8'hAA}};
  localparam logic [DW-1:0] C55 = {16{8'h55}};

  spu_register_file dut (
    .clock                    (clock),
    .reset                    (reset),
    .even_wb_data             (even_wb_data),
    .even_wb_reg_addr         (even_wb_reg_addr),
    .even_wb_enable_reg_write (even_wb_enable_reg_write),
    .odd_wb_data              (odd_wb_data),
    .odd_wb_reg_addr          (odd_wb_reg_addr),
    .odd_wb_enable_reg_write  (odd_wb_enable_reg_write),
    .even_stage_data          (even_stage_data),
    .even_stage_addr          (even_stage_addr),
    .even_stage_en            (even_stage_en),
    .odd_stage_data           (odd_stage_data),
    .odd_stage_addr           (odd_stage_addr),
    .odd_stage_en             (odd_stage_en),
    .rd_valid                 (rd_valid),
    .ra_addr                  (ra_addr),
    .rb_addr                  (rb_addr),
    .rc_addr                  (rc_addr),
    .ra_data                  (ra_data),
    .rb_data                  (rb_data),
    .rc_data                  (rc_data),
    .rd_data_valid            (rd_data_valid),
    .wb_collision             (wb_collision)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    even_wb_enable_reg_write = 1'b0;
    odd_wb_enable_reg_write  = 1'b0;
    even_stage_en            = '0;
    odd_stage_en             = '0;
    rd_valid                 = 1'b0;
  endtask

  initial begin
    reset            = 1'b0;
    even_wb_data     = '0;
    even_wb_reg_addr = '0;
    odd_wb_data      = '0;
    odd_wb_reg_addr  = '0;
    even_stage_data  = '0;
    even_stage_addr  = '0;
    odd_stage_data   = '0;
    odd_stage_addr   = '0;
    ra_addr          = '0;
    rb_addr          = '0;
    rc_addr          = '0;
    idle();
    tick();
    tick();
    chk("rst_ra", ra_data, '0);
    chk("rst_rdv", {127'd0, rd_data_valid}, 128'd0);
    chk("rst_col", {127'd0, wb_collision}, 128'd0);

    // read r0/r5/r127 after reset
    reset    = 1'b1;
    rd_valid = 1'b1;
    ra_addr  = 7'd0;
    rb_addr  = 7'd5;
    rc_addr  = 7'd127;
    tick();
    chk("r0", ra_data, '0);
    chk("r5", rb_data, '0);
    chk("r127", rc_data, '0);
    chk("rdv1", {127'd0, rd_data_valid}, 128'd1);

    // even write-back r10
    idle();
    even_wb_data             = C10;
    even_wb_reg_addr         = 7'd10;
    even_wb_enable_reg_write = 1'b1;
    tick();
    chk("rdv0", {127'd0, rd_data_valid}, 128'd0);
    idle();
    rd_valid = 1'b1;
    ra_addr  = 7'd10;
    tick();
    chk("rd_r10", ra_data, C10);

    // disabled write to r11 leaves it zero
    idle();
    even_wb_data     = CAA;
    even_wb_reg_addr = 7'd11;
    tick();
    rd_valid = 1'b1;
    ra_addr  = 7'd11;
    tick();
    chk("no_we_r11", ra_data, '0);

    // reset asserted mid-read clears outputs at once
    ra_addr = 7'd10;
    tick();
    chk("pre_rst", ra_data, C10);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ra", ra_data, '0);
    chk("mid_rst_rdv", {127'd0, rd_data_valid}, 128'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("r10_cleared", ra_data, '0);

    // same-address collision: odd wins
    idle();
    odd_wb_data              = CAA;
    odd_wb_reg_addr          = 7'd7;
    odd_wb_enable_reg_write  = 1'b1;
    even_wb_data             = C55;
    even_wb_reg_addr         = 7'd7;
    even_wb_enable_reg_write = 1'b1;
    tick();
    chk("col1", {127'd0, wb_collision}, 128'd1);
    idle();
    rd_valid = 1'b1;
    ra_addr  = 7'd7;
    tick();
    chk("col0", {127'd0, wb_collision}, 128'd0);
    chk("r7_odd", ra_data, CAA);

    // two writes to different addresses: no collision
    idle();
    even_wb_data             = 128'h20;
    even_wb_reg_addr         = 7'd20;
    even_wb_enable_reg_write = 1'b1;
    odd_wb_data              = 128'h21;
    odd_wb_reg_addr          = 7'd21;
    odd_wb_enable_reg_write  = 1'b1;
    tick();
    chk("nocol", {127'd0, wb_collision}, 128'd0);
    idle();
    rd_valid = 1'b1;
    rb_addr  = 7'd20;
    rc_addr  = 7'd21;
    tick();
    chk("r20", rb_data, 128'h20);
    chk("r21", rc_data, 128'h21);

    // staging priority on r3
    idle();
    even_wb_data             = 128'h1111;
    even_wb_reg_addr         = 7'd3;
    even_wb_enable_reg_write = 1'b1;
    tick();
    idle();
    rd_valid           = 1'b1;
    ra_addr            = 7'd3;
    even_stage_addr[2] = 7'd3;
    even_stage_data[2] = 128'h2222;
    even_stage_en[2]   = 1'b1;
    odd_stage_addr[0]  = 7'd3;
    odd_stage_data[0]  = 128'h3333;
    odd_stage_en[0]    = 1'b1;
    tick();
    chk("stg_odd0", ra_data, 128'h3333);
    odd_stage_en[0] = 1'b0;
    tick();
    chk("stg_even2", ra_data, 128'h2222);
    even_stage_en[2] = 1'b0;
    tick();
    chk("stg_array", ra_data, 128'h1111);

    // within one stage, odd beats even
    even_stage_addr[1] = 7'd3;
    even_stage_data[1] = 128'h6666;
    even_stage_en[1]   = 1'b1;
    odd_stage_addr[1]  = 7'd3;
    odd_stage_data[1]  = 128'h7777;
    odd_stage_en[1]    = 1'b1;
    tick();
    chk("stg1_odd", ra_data, 128'h7777);

    // oldest stage beats same-cycle write-back
    idle();
    rd_valid                = 1'b1;
    even_stage_addr[3]      = 7'd3;
    even_stage_data[3]      = 128'h4444;
    even_stage_en[3]        = 1'b1;
    odd_wb_data             = 128'h5555;
    odd_wb_reg_addr         = 7'd3;
    odd_wb_enable_reg_write = 1'b1;
    tick();
    chk("stg_over_wb", ra_data, 128'h4444);
    idle();
    rd_valid = 1'b1;
    tick();
    chk("r3_written", ra_data, 128'h5555);

    // flushed slots (en=0) never forward
    idle();
    even_wb_data             = 128'h4321;
    even_wb_reg_addr         = 7'd4;
    even_wb_enable_reg_write = 1'b1;
    tick();
    idle();
    rd_valid = 1'b1;
    ra_addr  = 7'd4;
    rb_addr  = 7'd0;
    for (int k = 0; k < ST; k++) begin
      even_stage_addr[k] = (k % 2 == 0) ? 7'd4 : 7'd0;
      even_stage_data[k] = 128'hFFFF;
      odd_stage_addr[k]  = (k % 2 == 0) ? 7'd0 : 7'd4;
      odd_stage_data[k]  = 128'hFFFF;
    end
    tick();
    chk("flush_r4", ra_data, 128'h4321);
    chk("flush_r0", rb_data, '0);

    // write-through on all three operands
    idle();
    odd_wb_data             = 128'hBEEF;
    odd_wb_reg_addr         = 7'd9;
    odd_wb_enable_reg_write = 1'b1;
    rd_valid                = 1'b1;
    ra_addr                 = 7'd9;
    rb_addr                 = 7'd9;
    rc_addr                 = 7'd9;
    tick();
    chk("wt_ra", ra_data, 128'hBEEF);
    chk("wt_rb", rb_data, 128'hBEEF);
    chk("wt_rc", rc_data, 128'hBEEF);
    idle();
    ra_addr = 7'd10;
    tick();
    chk("hold_ra", ra_data, 128'hBEEF);
    chk("hold_rdv", {127'd0, rd_data_valid}, 128'd0);

    // r0 is writable
    even_wb_data             = 128'h77;
    even_wb_reg_addr         = 7'd0;
    even_wb_enable_reg_write = 1'b1;
    tick();
    idle();
    rd_valid = 1'b1;
    ra_addr  = 7'd0;
    tick();
    chk("r0_write", ra_data, 128'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spu_register_file.md
Name: spu_register_file

Overview:
- 128-entry x 128-bit SPU register file: the consumer end of the write-back interface driven by the execution pipes.
- Accepts one write-back per cycle from the even pipe and one from the odd pipe; serves three operand reads (ra, rb, rc).
- Operand reads forward in-flight results from each pipe's staging registers.
- Sits between decode/issue and the execution pipes; operand outputs feed the pipes' src inputs.

Parameters:
- NUM_REGS, 128, number of architectural registers (address width 7)
- DATA_W, 128, register width in bits
- STAGES, 4, staging stages exposed by each pipe for forwarding (index 0 = youngest)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- even_wb_data  in  DATA_W  even-pipe write-back value
- even_wb_reg_addr  in  7  even-pipe write-back destination
- even_wb_enable_reg_write  in  1  even-pipe write strobe
- odd_wb_data  in  DATA_W  odd-pipe write-back value
- odd_wb_reg_addr  in  7  odd-pipe write-back destination
- odd_wb_enable_reg_write  in  1  odd-pipe write strobe
- even_stage_data  in  STAGES x DATA_W  even-pipe staging values
- even_stage_addr  in  STAGES x 7  even-pipe staging destinations
- even_stage_en  in  STAGES  even-pipe staging valid/write flags
- odd_stage_data, odd_stage_addr, odd_stage_en  in  same shapes  odd-pipe staging
- rd_valid  in  1  read request this cycle
- ra_addr, rb_addr, rc_addr  in  7 each  source register addresses
- ra_data, rb_data, rc_data  out  DATA_W each  operand values, registered
- rd_data_valid  out  1  operands valid (rd_valid delayed 1 cycle)
- wb_collision  out  1  pulse: both pipes wrote the same address this cycle

Behaviour:
- Reset (reset=0, asynchronous):
  - All array entries are 0.
  - ra_data, rb_data and rc_data are 0.
  - rd_data_valid and wb_collision are 0.
  - Exiting reset takes effect at the first rising clock edge with reset=1.
  - Reset asserted mid-operation discards in-progress reads and writes immediately.
- Writes: on the rising edge, array[even_wb_reg_addr] <= even_wb_data when even_wb_enable_reg_write=1; likewise for the odd port.
- Same-address collision (both enables 1, equal addresses):
  - The odd port wins.
  - wb_collision=1 for exactly the following cycle.
  - Otherwise wb_collision=0.
- Reads: one-cycle latency. When rd_valid=1 at edge N, ra/rb/rc_data and rd_data_valid=1 are presented after edge N.
- Operand outputs hold their value while rd_valid=0; rd_data_valid drops to 0.
- Per-operand source selection, evaluated combinationally at the sampling edge; first match wins:
  1. Staging stage k=0..STAGES-1, youngest first. Within a stage the odd pipe wins over the even pipe. A match needs stage_en[k]=1 and stage_addr[k]==operand address.
  2. Same-cycle write-back port (odd, then even) with enable=1 and matching address (write-through).
  3. Array contents.
- Entries with en=0 never forward, whatever their addr or data. This covers no-ops and branch-flushed slots, which carry addr 0 and en 0.
- Register 0 is an ordinary register: readable, writable and forwardable.
- Multiple operands may name the same register; each resolves independently and identically.
- A read never observes a partially applied write; all selection uses pre-edge input values.

Test Plan:
- Reset, then read r0/r5/r127 with rd_valid=1 -> one cycle later all three operands = 0, rd_data_valid=1; assert reset mid-read -> outputs 0 immediately.
- even wb r10=0x0123...EF, en=1; next cycle read ra=r10 -> ra_data=0x0123...EF with no staging match; with even_wb_enable_reg_write=0 instead -> ra_data=0.
- Same cycle: odd wb r7=0xAA..AA, even wb r7=0x55..55 -> wb_collision=1 next cycle; later read of r7 returns 0xAA..AA.
- Array r3=0x1111, even_stage[2]=(r3,0x2222,en=1), odd_stage[0]=(r3,0x3333,en=1) -> ra=r3 returns 0x3333; drop odd_stage_en[0] -> 0x2222; drop both -> 0x1111.
- Staging slot addr=r4, data=0xFFFF, en=0 (flushed branch slot) -> read r4 returns array value, not 0xFFFF.
- Read and same-cycle odd wb to r9=0xBEEF, ra=rb=rc=r9 -> all three outputs 0xBEEF after one cycle (write-through).
